// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
// Bundles the byte-write handshake and the transmitter status/line signals
// of uart_tx_fifo.
//   din      character to transmit (sampled when wr=1)
//   wr       one-cycle write strobe per character
//   tx       serial line, idle high
//   busy     transmitter FSM not in IDLE
//   empty    FIFO holds no entries
//   full     FIFO holds FIFO_DEPTH entries
//   fill     FIFO occupancy, 0..FIFO_DEPTH
//   overflow sticky flag, a write was dropped while full
// master: the character source; slave: the transmitter.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
) ();
  logic [7:0]      din;
  logic            wr;
  logic            tx;
  logic            busy;
  logic            empty;
  logic            full;
  logic [ADDR_W:0] fill;
  logic            overflow;

  modport master (
    output din, wr,
    input  tx, busy, empty, full, fill, overflow
  );

  modport slave (
    input  din, wr,
    output tx, busy, empty, full, fill, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// 8N1 UART transmitter (LSB first) fed by a circular byte FIFO that absorbs
// characters arriving without back-pressure.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  uart_tx_fifo_if.slave: din/wr in; tx/busy/empty/full/fill/overflow out
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_fifo_if.slave   bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  baud_r, baud_s;
  logic [2:0]        bit_r, bit_s;
  logic [7:0]        shift_r, shift_s;
  logic              tx_s;
  logic              pop_s;

  logic [7:0]        mem_r [FIFO_DEPTH];
  logic [ADDR_W-1:0] wptr_r, rptr_r;
  logic [ADDR_W:0]   count_r, count_s;
  logic              push_s, drop_s;
  logic              full_r, empty_r, overflow_r, tx_r, busy_r;

  // FIFO accept/drop decision and next occupancy, all from pre-edge state
  always_comb begin
    push_s  = bus.wr & ~full_r;
    drop_s  = bus.wr & full_r;
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + (ADDR_W+1)'(1);
      2'b01:   count_s = count_r - (ADDR_W+1)'(1);
      default: count_s = count_r;
    endcase
  end

  // FIFO storage; contents are don't-care until written so no reset here
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wptr_r] <= bus.din;
    end
  end

  // FIFO pointers, registered flags derived from the post-edge count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      count_r    <= '0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) wptr_r <= wptr_r + ADDR_W'(1);
      if (pop_s)  rptr_r <= rptr_r + ADDR_W'(1);
      count_r    <= count_s;
      full_r     <= (count_s == DEPTH_CNT);
      empty_r    <= (count_s == '0);
      overflow_r <= overflow_r | drop_s;
    end
  end

  // TX FSM next state, datapath and line value for the current state
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    tx_s    = 1'b1;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        tx_s = 1'b1;
        if (!empty_r) begin
          pop_s   = 1'b1;
          shift_s = mem_r[rptr_r];
          baud_s  = '0;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        tx_s = 1'b0;
        if (baud_r == BAUD_LAST) begin
          baud_s  = '0;
          bit_s   = 3'd0;
          state_s = DATA;
        end else begin
          baud_s  = baud_r + CNT_W'(1);
        end
      end
      DATA: begin
        tx_s = shift_r[0];
        if (baud_r == BAUD_LAST) begin
          baud_s  = '0;
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            state_s = STOP;
          end else begin
            bit_s   = bit_r + 3'd1;
          end
        end else begin
          baud_s  = baud_r + CNT_W'(1);
        end
      end
      STOP: begin
        tx_s = 1'b1;
        if (baud_r == BAUD_LAST) begin
          baud_s  = '0;
          state_s = IDLE;
        end else begin
          baud_s  = baud_r + CNT_W'(1);
        end
      end
      default: begin
        tx_s    = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

  // TX FSM registers; tx lags the state by one cycle so it stays glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      baud_r  <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  assign bus.tx       = tx_r;
  assign bus.busy     = busy_r;
  assign bus.empty    = empty_r;
  assign bus.full     = full_r;
  assign bus.fill     = count_r;
  assign bus.overflow = overflow_r;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-serial UART transmitter with an input FIFO. It sits directly downstream of the ASCII message sequencer and consumes its 8-bit character output and one-cycle strobe. The sequencer emits characters without back-pressure, so this block buffers them and serialises each one onto the board TX pin as 8N1 frames, LSB first.

## Interface
- CLKS_PER_BIT, 868, clock cycles per UART bit (115200 Bd at 100 MHz); must be ≥ 2.
- FIFO_DEPTH, 16, number of byte entries; must be a power of two.
- ADDR_W, 4, log2(FIFO_DEPTH).
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- din  in  8  character to transmit; sampled when wr=1.
- wr  in  1  write strobe, one cycle per character (the upstream tick).
- tx  out  1  serial line, registered; idle high.
- busy  out  1  high whenever the TX FSM is not in IDLE.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- fill  out  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky flag; set when a write is dropped, cleared only by rst.

## Operation
- Reset values: tx=1, busy=0, empty=1, full=0, fill=0, overflow=0. Read/write pointers, bit counter, baud counter and shift register are all cleared; state=IDLE.
- FIFO:
  - Circular buffer, ADDR_W-bit pointers that wrap modulo FIFO_DEPTH.
  - A write is accepted when wr=1 and fill<FIFO_DEPTH, judged on pre-edge values.
  - wr=1 with full=1 drops the byte, sets overflow, and leaves pointers and fill unchanged.
  - A pop and a write in the same cycle leave fill unchanged and both pointers advance.
  - full, empty and fill are registered and derived from the post-edge count.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If empty=0, pop the head byte into the shift register, clear the baud counter, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- The baud counter runs 0..CLKS_PER_BIT-1; the bit boundary is at CLKS_PER_BIT-1.
- The bit index is 3 bits and needs no wrap handling.
- A pop happens only in IDLE, so a pop never coincides with the FIFO being read while empty.
- The FIFO may be written during any TX state.

## Timing
- Write at edge N into an empty FIFO with the FSM in IDLE:
  - edge N+1: pop, state=START.
  - edge N+2: tx falls (tx is registered from the state).
- Frame length is exactly 10×CLKS_PER_BIT cycles of tx (start, 8 data bits, stop).
- Back-to-back frames: one IDLE cycle between STOP end and the next pop, so start-to-start spacing is 10×CLKS_PER_BIT+1 cycles.
- With consecutive wr every cycle into an idle empty block, the first byte is popped one cycle after its write. FIFO_DEPTH+1 bytes are therefore accepted before the first drop.
- Asserting rst mid-frame forces tx=1 immediately (asynchronously) and discards all FIFO content. After release, the next wr starts a fresh frame with the same N+2 latency.
- din is ignored when wr=0. wr held high for k cycles means k writes.

## Test plan
- Reset check with CLKS_PER_BIT=4: hold rst, toggle clk -> tx=1, busy=0, empty=1, fill=0, overflow=0.
- Single byte 0x56 ('V') at edge N -> tx falls at edge N+2; bits 0,1,1,0,1,0,1,0 each 4 cycles; stop=1; busy low after 40 cycles; empty=1.
- Burst of the 14-byte line "V01 - 0123 V\n\r" on consecutive wr strobes -> all 14 bytes appear in order on tx; overflow=0; start-to-start spacing 41 cycles; peak fill=13.
- 18 consecutive writes 0x00..0x11 with FIFO_DEPTH=16 -> bytes 0x00..0x10 transmitted in order; 0x11 dropped; overflow=1 from the edge of the 18th write; full=1 at edge 16.
- rst asserted during DATA bit 3 of 0x41 with 3 bytes queued -> tx=1 immediately; fill=0, busy=0. After release, a write of 0x30 -> a clean frame 0x30 and nothing else.
- Pointer wrap: 40 bytes written in 3 groups spaced so fill never exceeds 15 -> all 40 bytes serialised in order; overflow=0.
